// File: rtl/rom_fetch_buffer.sv
// rom_fetch_buffer
//   One-line instruction buffer between the core fetch port and the ROM.
//   Hits on the buffered line are acknowledged on the cycle after the request
//   is sampled. Misses run the ROM enable/busy transaction, capture the line
//   and then acknowledge.
//
//   Optional feature macro: ROM_PREFETCH_EN
//     When defined, a second line slot is fetched in the background. The target
//     is the line after the one just delivered to the core.
//
// Handshakes:
//   cpu_req is held by the core until cpu_ack. cpu_ack is a one-cycle pulse,
//   and cpu_data is valid only in that cycle. cpu_req and cpu_addr are sampled
//   only in IDLE.
//   rom_enable is a one-cycle pulse. rom_addr is held from that pulse until the
//   line is captured. The ROM answers by raising rom_busy and then dropping it.
//   rom_data is captured on the cycle after busy falls.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-low reset
//   cpu_req    fetch request
//   cpu_addr   word address; low offset bits are ignored
//   cpu_ack    one-cycle acknowledge
//   cpu_data   fetched line; zero outside the acknowledge cycle
//   rom_enable one-cycle ROM request
//   rom_addr   line-aligned ROM address
//   rom_data   ROM line output
//   rom_busy   ROM busy
//   error      sticky; the ROM never raised busy within busy_timeout cycles
//   dbg_state  current FSM state, for observation
module rom_fetch_buffer #(
    parameter int word_size    = 8,
    parameter int addr_size    = 8,
    parameter int offset       = 2,
    parameter int busy_timeout = 15
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              cpu_req,
    input  logic [addr_size-1:0]              cpu_addr,
    output logic                              cpu_ack,
    output logic [word_size*(2**offset)-1:0]  cpu_data,
    output logic                              rom_enable,
    output logic [addr_size-1:0]              rom_addr,
    input  logic [word_size*(2**offset)-1:0]  rom_data,
    input  logic                              rom_busy,
    output logic                              error,
    output logic [2:0]                        dbg_state
);

    localparam int line_w = word_size * (2 ** offset);
    localparam int tag_w  = addr_size - offset;
    localparam int cnt_w  = $clog2(busy_timeout + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ     = 3'd1;
    localparam logic [2:0] WAIT_HI = 3'd2;
    localparam logic [2:0] WAIT_LO = 3'd3;
    localparam logic [2:0] FILL    = 3'd4;
    localparam logic [2:0] ACK     = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [line_w-1:0] buf_data_q, buf_data_d;
    logic [tag_w-1:0]  buf_tag_q, buf_tag_d;
    logic              buf_valid_q, buf_valid_d;
    logic [tag_w-1:0]  rom_tag_q, rom_tag_d;
    logic [cnt_w-1:0]  cnt_q, cnt_d;
    logic              error_q, error_d;

    logic [tag_w-1:0]  cpu_tag;
    logic              hit;
    logic              unused_addr_bits;

    assign cpu_tag          = cpu_addr[addr_size-1:offset];
    assign hit              = cpu_req && buf_valid_q && (buf_tag_q == cpu_tag);
    assign unused_addr_bits = ^cpu_addr[offset-1:0];

`ifdef ROM_PREFETCH_EN
    logic [line_w-1:0] pf_data_q, pf_data_d;
    logic [tag_w-1:0]  pf_tag_q, pf_tag_d;
    logic              pf_valid_q, pf_valid_d;
    // Set while the ROM transaction in flight is a background prefetch.
    logic              pf_active_q, pf_active_d;
    // Set when the ACK in progress should launch a prefetch of the next line.
    logic              pf_next_q, pf_next_d;
    logic              pf_hit;

    assign pf_hit = cpu_req && pf_valid_q && (pf_tag_q == cpu_tag);
`endif

    always_comb begin
        state_d     = state_q;
        buf_data_d  = buf_data_q;
        buf_tag_d   = buf_tag_q;
        buf_valid_d = buf_valid_q;
        rom_tag_d   = rom_tag_q;
        cnt_d       = cnt_q;
        error_d     = error_q;
`ifdef ROM_PREFETCH_EN
        pf_data_d   = pf_data_q;
        pf_tag_d    = pf_tag_q;
        pf_valid_d  = pf_valid_q;
        pf_active_d = pf_active_q;
        pf_next_d   = pf_next_q;
`endif
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = ACK;
`ifdef ROM_PREFETCH_EN
                end else if (pf_hit) begin
                    // Promote the prefetched line; the ACK then refills the slot.
                    buf_data_d  = pf_data_q;
                    buf_tag_d   = pf_tag_q;
                    buf_valid_d = 1'b1;
                    pf_valid_d  = 1'b0;
                    pf_next_d   = 1'b1;
                    state_d     = ACK;
`endif
                end else if (cpu_req) begin
                    rom_tag_d = cpu_tag;
`ifdef ROM_PREFETCH_EN
                    pf_active_d = 1'b0;
`endif
                    state_d = REQ;
                end
            end
            REQ: begin
                cnt_d   = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                // Busy is looked at only from here on, never in the enable cycle.
                if (rom_busy) begin
                    state_d = WAIT_LO;
                end else if (cnt_q == cnt_w'(busy_timeout - 1)) begin
                    // A pending core request is retried from IDLE.
                    // A prefetch that times out is simply dropped.
                    error_d = 1'b1;
`ifdef ROM_PREFETCH_EN
                    pf_active_d = 1'b0;
`endif
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + cnt_w'(1);
                end
            end
            WAIT_LO: begin
                if (!rom_busy) begin
                    state_d = FILL;
                end
            end
            FILL: begin
`ifdef ROM_PREFETCH_EN
                if (pf_active_q) begin
                    pf_data_d   = rom_data;
                    pf_tag_d    = rom_tag_q;
                    pf_valid_d  = 1'b1;
                    pf_active_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    buf_data_d  = rom_data;
                    buf_tag_d   = rom_tag_q;
                    buf_valid_d = 1'b1;
                    pf_next_d   = 1'b1;
                    state_d     = ACK;
                end
`else
                buf_data_d  = rom_data;
                buf_tag_d   = rom_tag_q;
                buf_valid_d = 1'b1;
                state_d     = ACK;
`endif
            end
            ACK: begin
`ifdef ROM_PREFETCH_EN
                if (pf_next_q) begin
                    // Next sequential line; the tag wraps from all-ones to zero.
                    rom_tag_d   = buf_tag_q + tag_w'(1);
                    pf_active_d = 1'b1;
                    pf_next_d   = 1'b0;
                    state_d     = REQ;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            buf_data_q  <= '0;
            buf_tag_q   <= '0;
            buf_valid_q <= 1'b0;
            rom_tag_q   <= '0;
            cnt_q       <= '0;
            error_q     <= 1'b0;
`ifdef ROM_PREFETCH_EN
            pf_data_q   <= '0;
            pf_tag_q    <= '0;
            pf_valid_q  <= 1'b0;
            pf_active_q <= 1'b0;
            pf_next_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            buf_data_q  <= buf_data_d;
            buf_tag_q   <= buf_tag_d;
            buf_valid_q <= buf_valid_d;
            rom_tag_q   <= rom_tag_d;
            cnt_q       <= cnt_d;
            error_q     <= error_d;
`ifdef ROM_PREFETCH_EN
            pf_data_q   <= pf_data_d;
            pf_tag_q    <= pf_tag_d;
            pf_valid_q  <= pf_valid_d;
            pf_active_q <= pf_active_d;
            pf_next_q   <= pf_next_d;
`endif
        end
    end

    assign cpu_ack    = (state_q == ACK);
    assign cpu_data   = (state_q == ACK) ? buf_data_q : '0;
    assign rom_enable = (state_q == REQ);
    assign rom_addr   = {rom_tag_q, {offset{1'b0}}};
    assign error      = error_q;
    assign dbg_state  = state_q;

endmodule
